// File: rtl/mmio_pkg.sv
// Shared data-memory bus encodings, register offsets, STATUS layout and UART FSM states.
// Also holds the load extension helper used by memory-mapped responders.
package mmio_pkg;

   typedef enum logic [2:0] {
      RD_NONE = 3'b000,
      RD_LB   = 3'b001,
      RD_LBU  = 3'b010,
      RD_LH   = 3'b011,
      RD_LHU  = 3'b100,
      RD_LW   = 3'b101
   } rd_ctrl_e;

   typedef enum logic [1:0] {
      WR_NONE = 2'b00,
      WR_SB   = 2'b01,
      WR_SH   = 2'b10,
      WR_SW   = 2'b11
   } wr_ctrl_e;

   localparam logic [3:0] TXDATA_OFS = 4'h0;
   localparam logic [3:0] STATUS_OFS = 4'h4;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_EMPTY   = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // Lane select and sign/zero extension of a register word for the core's load types.
   function automatic logic [31:0] load_extend(input logic [2:0]  rd_ctrl,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (rd_ctrl)
         RD_LB:   load_extend = {{24{b[7]}}, b};
         RD_LBU:  load_extend = {24'h0, b};
         RD_LH:   load_extend = {{16{h[15]}}, h};
         RD_LHU:  load_extend = {16'h0, h};
         RD_LW:   load_extend = word;
         default: load_extend = '0;
      endcase
   endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory bus as seen by a memory-mapped responder.
interface mmio_uart_tx_if;
   logic [31:0] dm_addr;
   logic [2:0]  dm_rd_ctrl;
   logic [1:0]  dm_wr_ctrl;
   logic [31:0] dm_din;
   logic [31:0] dm_dout;
   logic        hit;

   modport master (output dm_addr, dm_rd_ctrl, dm_wr_ctrl, dm_din,
                   input  dm_dout, hit);
   modport slave  (input  dm_addr, dm_rd_ctrl, dm_wr_ctrl, dm_din,
                   output dm_dout, hit);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full or a pop while empty is ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = count == FULL_CNT;
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes, STATUS is polled by loads.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | line high, waiting for a queued byte
// ST_START | start bit, line low for one bit period
// ST_DATA  | eight data bits, LSB first
// ST_STOP  | stop bit, line high; a queued byte goes straight to ST_START
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   mmio_uart_tx_if.slave bus,
   output logic          txd
);
   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_TC = 16'(CLK_DIV - 1);

   tx_state_e     state;
   tx_state_e     state_nxt;
   logic [15:0]   baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          bit_done;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic          wr_hit;
   logic          ovf_clr;
   logic [31:0]   status;
   logic [31:0]   reg_word;
   logic          unused_din;

   // Registers are decoded per word; the byte lane only matters for load extension.
   assign bus.hit    = bus.dm_addr[31:4] == BASE_ADDR[31:4];
   assign wr_hit     = bus.hit && (bus.dm_wr_ctrl != WR_NONE);
   assign fifo_push  = wr_hit && (bus.dm_addr[3:2] == TXDATA_OFS[3:2]);
   assign ovf_clr    = wr_hit && (bus.dm_addr[3:2] == STATUS_OFS[3:2]);
   assign unused_din = ^bus.dm_din[31:8];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (bus.dm_din[7:0]),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Full is the pre-edge view, so a pop on the same edge never rescues the byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                        overflow <= 1'b0;
      else if (fifo_push && fifo_full) overflow <= 1'b1;
      else if (ovf_clr)                overflow <= 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!fifo_empty) state_nxt = ST_START;
         ST_START: if (bit_done) state_nxt = ST_DATA;
         ST_DATA:  if (bit_done && bit_idx == 3'd7) state_nxt = ST_STOP;
         ST_STOP:  if (bit_done) state_nxt = fifo_empty ? ST_IDLE : ST_START;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      txd      = 1'b1;
      fifo_pop = 1'b0;
      case (state)
         ST_IDLE:  fifo_pop = !fifo_empty;
         ST_START: txd = 1'b0;
         ST_DATA:  txd = shift[0];
         ST_STOP:  fifo_pop = bit_done && !fifo_empty;
         default:  ;
      endcase
   end

   // Bit timer counts down from CLK_DIV-1; terminal count ends the current bit.
   assign bit_done = baud_cnt == '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else if (fifo_pop) begin
         shift    <= fifo_rdata;
         baud_cnt <= BAUD_TC;
      end else if (state != ST_IDLE) begin
         if (bit_done) begin
            baud_cnt <= BAUD_TC;
            if (state == ST_START) bit_idx <= '0;
            if (state == ST_DATA) begin
               shift <= shift >> 1;
               if (bit_idx != 3'd7) bit_idx <= bit_idx + 3'd1;
            end
         end else begin
            baud_cnt <= baud_cnt - 16'd1;
         end
      end
   end

   always_comb begin
      status                     = '0;
      status[STAT_BUSY]          = state != ST_IDLE;
      status[STAT_FULL]          = fifo_full;
      status[STAT_EMPTY]         = fifo_empty;
      status[STAT_OVF]           = overflow;
      status[STAT_CNT_LSB +: CW] = fifo_count;
   end

   assign reg_word    = (bus.dm_addr[3:2] == STATUS_OFS[3:2]) ? status : '0;
   assign bus.dm_dout = bus.hit ? load_extend(bus.dm_rd_ctrl, bus.dm_addr[1:0], reg_word) : '0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: table-driven loads plus a txd frame monitor fed by a byte scoreboard.
module tb_mmio_uart_tx;
   import mmio_pkg::*;

   localparam int          CLK_DIV = 4;
   localparam int          FRAME   = 10 * CLK_DIV;
   localparam logic [31:0] BASE    = 32'h1000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic txd;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   last_wr_cyc = 0;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(
      .BASE_ADDR  (BASE),
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .txd (txd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // ---------------- scoreboard and txd frame monitor ----------------
   logic [7:0] sb_q[$];
   int         start_q[$];
   int         frames_seen = 0;
   int         mon_p = -1;
   int         mon_bad = 0;
   logic [7:0] mon_byte = '0;
   logic [7:0] mon_exp = '0;
   logic       exp_lvl;

   always @(negedge clk) begin
      if (!rst) begin
         mon_p = -1;
      end else begin
         if (mon_p < 0 && txd == 1'b0) begin
            mon_p   = 0;
            mon_bad = 0;
            start_q.push_back(cyc);
            check("frame_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) mon_exp = sb_q.pop_front();
            else                  mon_exp = 8'h00;
         end
         if (mon_p >= 0) begin
            if (mon_p < 4)       exp_lvl = 1'b0;
            else if (mon_p < 36) exp_lvl = mon_exp[3'((mon_p - 4) / 4)];
            else                 exp_lvl = 1'b1;
            if (txd !== exp_lvl) mon_bad++;
            if (mon_p >= 4 && mon_p < 36 && (mon_p % 4) == 2)
               mon_byte[3'((mon_p - 4) / 4)] = txd;
            if (mon_p == FRAME - 1) begin
               check("frame_byte", 32'(mon_byte), 32'(mon_exp));
               check("frame_shape_bad_cycles", 32'(mon_bad), 32'd0);
               frames_seen++;
               mon_p = -1;
            end else begin
               mon_p++;
            end
         end
      end
   end

   // ---------------- bus drivers ----------------
   task automatic bus_write(input logic [31:0] addr, input logic [1:0] wr, input logic [31:0] data);
      @(negedge clk);
      bus.dm_addr    = addr;
      bus.dm_wr_ctrl = wr;
      bus.dm_din     = data;
      bus.dm_rd_ctrl = RD_NONE;
      @(posedge clk);
      #1;
      bus.dm_wr_ctrl = WR_NONE;
      last_wr_cyc    = cyc;
   endtask

   task automatic bus_read(input logic [31:0] addr, input logic [2:0] rd,
                           output logic [31:0] dout, output logic h);
      @(negedge clk);
      bus.dm_addr    = addr;
      bus.dm_rd_ctrl = rd;
      bus.dm_wr_ctrl = WR_NONE;
      #1;
      dout           = bus.dm_dout;
      h              = bus.hit;
      bus.dm_rd_ctrl = RD_NONE;
   endtask

   task automatic wait_drain(input int max_cyc);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || mon_p >= 0) && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      if (n >= max_cyc) check("drain_timeout", 32'(n), 32'(max_cyc - 1));
   endtask

   // ---------------- load vector table ----------------
   typedef struct {
      int          grp;
      logic [2:0]  rd;
      logic [31:0] addr;
      logic        hit;
      logic [31:0] dout;
   } load_vec_t;

   load_vec_t vecs[$];

   task automatic run_group(input int g);
      logic [31:0] d;
      logic        h;
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].grp == g) begin
            bus_read(vecs[i].addr, vecs[i].rd, d, h);
            check1($sformatf("load_hit[%0d]", i), h, vecs[i].hit);
            check($sformatf("load_dout[%0d]", i), d, vecs[i].dout);
         end
      end
   endtask

   // ---------------- main sequence ----------------
   logic [31:0] d;
   logic        h;
   int          n_busy;
   int          f0;

   initial begin
      bus.dm_addr    = '0;
      bus.dm_rd_ctrl = RD_NONE;
      bus.dm_wr_ctrl = WR_NONE;
      bus.dm_din     = '0;

      // group 0: idle after reset (STATUS = empty)
      vecs.push_back('{0, RD_LW,   BASE + 32'h4, 1'b1, 32'h0000_0004});
      vecs.push_back('{0, RD_LBU,  BASE + 32'h4, 1'b1, 32'h0000_0004});
      vecs.push_back('{0, RD_LB,   BASE + 32'h4, 1'b1, 32'h0000_0004});
      vecs.push_back('{0, RD_LHU,  BASE + 32'h4, 1'b1, 32'h0000_0004});
      vecs.push_back('{0, RD_LH,   BASE + 32'h6, 1'b1, 32'h0000_0000});
      vecs.push_back('{0, RD_LBU,  BASE + 32'h5, 1'b1, 32'h0000_0000});
      vecs.push_back('{0, RD_LW,   BASE + 32'h0, 1'b1, 32'h0000_0000});
      vecs.push_back('{0, RD_LW,   BASE + 32'h8, 1'b1, 32'h0000_0000});
      vecs.push_back('{0, RD_LW,   BASE + 32'hC, 1'b1, 32'h0000_0000});
      vecs.push_back('{0, RD_NONE, BASE + 32'h4, 1'b1, 32'h0000_0000});
      vecs.push_back('{0, RD_LW,   32'h2000_0004, 1'b0, 32'h0000_0000});
      vecs.push_back('{0, RD_LW,   32'h1000_0014, 1'b0, 32'h0000_0000});
      vecs.push_back('{0, RD_LW,   32'h0FFF_FFFC, 1'b0, 32'h0000_0000});
      // group 1: mid-frame, FIFO empty (busy + empty)
      vecs.push_back('{1, RD_LBU,  BASE + 32'h4, 1'b1, 32'h0000_0005});
      vecs.push_back('{1, RD_LH,   BASE + 32'h6, 1'b1, 32'h0000_0000});
      vecs.push_back('{1, RD_LW,   BASE + 32'h8, 1'b1, 32'h0000_0000});
      vecs.push_back('{1, RD_LW,   BASE + 32'h4, 1'b1, 32'h0000_0005});
      // group 2: full FIFO with overflow (count 4, ovf, full, busy)
      vecs.push_back('{2, RD_LW,   BASE + 32'h4, 1'b1, 32'h0000_004B});
      vecs.push_back('{2, RD_LBU,  BASE + 32'h4, 1'b1, 32'h0000_004B});
      vecs.push_back('{2, RD_LB,   BASE + 32'h4, 1'b1, 32'h0000_004B});
      vecs.push_back('{2, RD_LHU,  BASE + 32'h6, 1'b1, 32'h0000_0000});
      vecs.push_back('{2, RD_LBU,  BASE + 32'h5, 1'b1, 32'h0000_0000});

      // reset
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check1("rst_txd", txd, 1'b1);
      bus_read(32'h2000_0000, RD_LW, d, h);
      check1("rst_miss_hit", h, 1'b0);
      check("rst_miss_dout", d, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check1("post_rst_txd", txd, 1'b1);
      run_group(0);

      // single byte with busy window
      sb_q.push_back(8'hA5);
      bus_write(BASE, WR_SB, 32'hFFFF_FFA5);
      n_busy = 0;
      for (int i = 0; i < 45; i++) begin
         bus_read(BASE + 32'h4, RD_LW, d, h);
         if (i == 0) check("sb_status_prepop", d, 32'h0000_0010);
         if (d[STAT_BUSY]) n_busy++;
      end
      check("sb_busy_cycles", 32'(n_busy), 32'd40);
      check("sb_status_done", d, 32'h0000_0004);
      wait_drain(100);
      check("sb_start_latency", 32'(start_q[$] - last_wr_cyc), 32'd1);

      // loads while a frame is in flight
      sb_q.push_back(8'h3C);
      bus_write(BASE, WR_SB, 32'h0000_003C);
      repeat (2) @(posedge clk);
      run_group(1);
      wait_drain(100);

      // back-to-back word stores, no idle gap between frames
      f0 = frames_seen;
      sb_q.push_back(8'h55);
      sb_q.push_back(8'hAA);
      bus_write(BASE, WR_SW, 32'h0000_1155);
      bus_write(BASE, WR_SW, 32'h0000_22AA);
      bus_read(BASE + 32'h4, RD_LW, d, h);
      check("b2b_count", 32'(d[8:4]), 32'd1);
      wait_drain(200);
      check("b2b_frames", 32'(frames_seen - f0), 32'd2);
      check("b2b_gap", 32'(start_q[$] - start_q[$-1]), 32'(FRAME));

      // overflow: six stores while idle, sixth dropped
      f0 = frames_seen;
      for (int i = 1; i <= 6; i++) begin
         if (i <= 5) sb_q.push_back(8'(i));
         bus_write(BASE, WR_SB, 32'(i));
      end
      run_group(2);
      bus_write(BASE + 32'h4, WR_SW, 32'h0);
      bus_read(BASE + 32'h4, RD_LW, d, h);
      check("ovf_cleared_status", d, 32'h0000_0043);
      wait_drain(400);
      check("ovf_frames", 32'(frames_seen - f0), 32'd5);
      bus_read(BASE + 32'h4, RD_LW, d, h);
      check("ovf_final_status", d, 32'h0000_0004);

      // writes that must not queue anything
      f0 = frames_seen;
      bus_write(BASE + 32'h8, WR_SB, 32'h11);
      bus_write(BASE + 32'hC, WR_SW, 32'h22);
      bus_write(BASE + 32'h4, WR_SH, 32'h33);
      bus_write(32'h2000_0000, WR_SB, 32'h44);
      repeat (60) @(posedge clk);
      check("ign_frames", 32'(frames_seen - f0), 32'd0);
      bus_read(BASE + 32'h4, RD_LW, d, h);
      check("ign_status", d, 32'h0000_0004);

      // halfword store queues only the low byte
      f0 = frames_seen;
      sb_q.push_back(8'h81);
      bus_write(BASE, WR_SH, 32'hFFFF_7E81);
      wait_drain(100);
      check("sh_frames", 32'(frames_seen - f0), 32'd1);

      // reset during data bit 3 of 0xA5 (bit value 0)
      f0 = frames_seen;
      sb_q.push_back(8'hA5);
      bus_write(BASE, WR_SB, 32'h0000_00A5);
      repeat (18) @(posedge clk);
      #3;
      check1("mid_bit3_txd", txd, 1'b0);
      rst = 1'b0;
      #1;
      check1("mid_rst_txd", txd, 1'b1);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bus_read(BASE + 32'h4, RD_LW, d, h);
      check("mid_rst_status", d, 32'h0000_0004);
      repeat (60) @(posedge clk);
      check("mid_rst_frames", 32'(frames_seen - f0), 32'd0);
      check1("mid_rst_txd_idle", txd, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
